// File: rtl/me_stage_pkg.sv
// Shared types and helpers for the RV32I memory-access stage: op encodings,
// FSM states, writeback constants and the store-lane / misalignment rules.
package me_stage_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } me_state_e;

  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
  localparam logic [31:0] ZERO_WORD     = 32'd0;

  function automatic logic is_load(mem_op_e op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(mem_op_e op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic is_misaligned(mem_op_e op, logic [1:0] lo);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return lo[0];
      MEM_LW, MEM_SW:          return lo != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(mem_op_e op, logic [1:0] lo);
    case (op)
      MEM_SB:  return 4'b0001 << lo;
      MEM_SH:  return 4'b0011 << {lo[1], 1'b0};
      MEM_SW:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Narrow stores are replicated so every enabled lane sees the right bytes.
  function automatic logic [31:0] store_wdata(mem_op_e op, logic [31:0] data);
    case (op)
      MEM_SB:  return {4{data[7:0]}};
      MEM_SH:  return {2{data[15:0]}};
      MEM_SW:  return data;
      default: return ZERO_WORD;
    endcase
  endfunction

endpackage

// File: rtl/me_stage_if.sv
// Data-bus request/acknowledge channel between the memory stage (master)
// and the data memory or bus fabric (slave).
interface me_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, wmask, input ack, rdata);
  modport slave  (input req, we, addr, wdata, wmask, output ack, rdata);
endinterface

// File: rtl/me_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it according to the load op.
module me_load_align
  import me_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  mem_op_e     op_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no latch is inferred.
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    case (op_i)
      MEM_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: data_o = {24'd0, byte_sel};
      MEM_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/me_stage.sv
// Memory-access stage: passes ALU results straight through, runs one bus
// transaction per load/store via an IDLE/ACCESS/DONE FSM, and stalls upstream.
module me_stage
  import me_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_w_enable_i,
  input  logic [4:0]  ex_w_addr_i,
  input  logic [31:0] ex_w_data_i,
  input  mem_op_e     ex_mem_op_i,
  input  logic [31:0] ex_mem_addr_i,
  input  logic [31:0] ex_store_data_i,
  output logic        me_w_enable_o,
  output logic [4:0]  me_w_addr_o,
  output logic [31:0] me_w_data_o,
  output logic        stall_req_o,
  output logic        misaligned_o,
  me_stage_if.master  dbus
);

  me_state_e   state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic        we_q;
  logic [1:0]  lo_q;
  mem_op_e     op_q;
  logic        mis_now;
  logic        start_access;
  logic [31:0] load_data;

  assign mis_now      = is_misaligned(ex_mem_op_i, ex_mem_addr_i[1:0]);
  assign start_access = (state_q == ST_IDLE) && (state_d == ST_ACCESS);

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE:   if (ex_mem_op_i != MEM_NONE && !mis_now) state_d = ST_ACCESS;
      ST_ACCESS: if (dbus.ack) begin
                   state_d = ST_DONE;
                   rdata_d = dbus.rdata;
                 end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rdata_q <= ZERO_WORD;
      addr_q  <= ZERO_WORD;
      wdata_q <= ZERO_WORD;
      wmask_q <= 4'b0000;
      we_q    <= 1'b0;
      lo_q    <= 2'b00;
      op_q    <= MEM_NONE;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (start_access) begin
        addr_q  <= {ex_mem_addr_i[31:2], 2'b00};
        wdata_q <= store_wdata(ex_mem_op_i, ex_store_data_i);
        wmask_q <= store_mask(ex_mem_op_i, ex_mem_addr_i[1:0]);
        we_q    <= is_store(ex_mem_op_i);
        lo_q    <= ex_mem_addr_i[1:0];
        op_q    <= ex_mem_op_i;
      end
    end
  end

  me_load_align u_load_align (
    .rdata_i   (rdata_q),
    .addr_lo_i (lo_q),
    .op_i      (op_q),
    .data_o    (load_data)
  );

  // Bus fields come straight from flops, so they hold steady across wait states.
  assign dbus.req   = (state_q == ST_ACCESS);
  assign dbus.we    = we_q;
  assign dbus.addr  = addr_q;
  assign dbus.wdata = wdata_q;
  assign dbus.wmask = wmask_q;

  always_comb begin
    me_w_enable_o = WRITE_DISABLE;
    me_w_addr_o   = ex_w_addr_i;
    me_w_data_o   = ex_w_data_i;
    stall_req_o   = 1'b0;
    misaligned_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ex_mem_op_i == MEM_NONE) me_w_enable_o = ex_w_enable_i;
        else if (mis_now)            misaligned_o  = 1'b1;
        else                         stall_req_o   = 1'b1;
      end
      ST_ACCESS: stall_req_o = 1'b1;
      ST_DONE: begin
        if (is_load(op_q)) begin
          me_w_enable_o = ex_w_enable_i;
          me_w_data_o   = load_data;
        end
      end
      default: stall_req_o = 1'b0;
    endcase
    // The writeback path is combinational from EX/ME, so reset forces it quiet too.
    if (!rst_n) begin
      me_w_enable_o = WRITE_DISABLE;
      me_w_addr_o   = NOP_REG_ADDR;
      me_w_data_o   = ZERO_WORD;
      stall_req_o   = 1'b0;
      misaligned_o  = 1'b0;
    end
  end

endmodule
